// File: rtl/vga_scanout_if.sv
// Framebuffer read port between the scan-out engine (master) and the memory (slave).
interface vga_scanout_if #(
   parameter int ADDR_W = 32
);
   // No valid/ready: fb_addr may change once per pixel period, and px_data must
   // follow it within CLK_DIV-1 clocks; the master samples px_data only at period end.
   logic [ADDR_W-1:0] fb_addr;
   logic [23:0]       px_data;

   modport master (output fb_addr, input px_data);
   modport slave  (input fb_addr, output px_data);
endinterface

// File: rtl/vga_scanout.sv
// Framebuffer scan-out engine: pixel divider, h/v timing, address generation, registered RGB.
// Optional colour-bar test pattern with input test_en when VGA_TESTPAT_EN is defined.
module vga_scanout #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0,
   parameter int CLK_DIV  = 2,
   parameter int SCALE    = 1,
   parameter int ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] FB_BASE = '0,
   parameter int STRIDE   = 4
) (
   input  logic                clk,
   input  logic                reset,
`ifdef VGA_TESTPAT_EN
   input  logic                test_en,
`endif
   vga_scanout_if.master       fb,
   output logic                pix_en,
   output logic                vga_clk,
   output logic                vga_hsync,
   output logic                vga_vsync,
   output logic                vga_blank_n,
   output logic [7:0]          vga_red,
   output logic [7:0]          vga_green,
   output logic [7:0]          vga_blue,
   output logic                frame_start,
   output logic                vblank
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW      = $clog2(H_TOTAL + 1);
   localparam int VW      = $clog2(V_TOTAL + 1);
   localparam int DW      = $clog2(CLK_DIV);
   localparam int SH      = (SCALE == 4) ? 2 : (SCALE == 2) ? 1 : 0;

   localparam logic [DW-1:0]     DIV_LAST   = DW'(CLK_DIV - 1);
   localparam logic [DW-1:0]     DIV_HALF   = DW'(CLK_DIV / 2);
   localparam logic [HW-1:0]     H_ACT_C    = HW'(H_ACTIVE);
   localparam logic [HW-1:0]     H_LAST_C   = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0]     HS_START_C = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0]     HS_END_C   = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VW-1:0]     V_ACT_C    = VW'(V_ACTIVE);
   localparam logic [VW-1:0]     V_LAST_C   = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0]     VS_START_C = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0]     VS_END_C   = VW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [ADDR_W-1:0] ROW_PIX_C  = ADDR_W'(H_ACTIVE / SCALE);
   localparam logic [ADDR_W-1:0] STRIDE_C   = ADDR_W'(STRIDE);

   if (CLK_DIV < 2) begin : g_bad_clk_div
      $error("vga_scanout: CLK_DIV must be at least 2");
   end
   if (SCALE != 1 && SCALE != 2 && SCALE != 4) begin : g_bad_scale
      $error("vga_scanout: SCALE must be 1, 2 or 4");
   end
   if ((H_ACTIVE % SCALE) != 0 || (V_ACTIVE % SCALE) != 0) begin : g_bad_active
      $error("vga_scanout: H_ACTIVE and V_ACTIVE must be multiples of SCALE");
   end

   logic [DW-1:0]     div;
   logic [DW-1:0]     div_nxt;
   logic [HW-1:0]     hcnt;
   logic [HW-1:0]     hcnt_nxt;
   logic [VW-1:0]     vcnt;
   logic [VW-1:0]     vcnt_nxt;
   logic              h_last;
   logic              v_last;

   logic              act0;
   logic              hs0;
   logic              vs0;
   logic [ADDR_W-1:0] row0;
   logic [ADDR_W-1:0] col0;
   logic [ADDR_W-1:0] addr0;

   logic              act_d;
   logic              hs_d;
   logic              vs_d;
   logic [23:0]       rgb_nxt;

   // Divider and raster counters
   always_comb begin
      div_nxt  = (div == DIV_LAST) ? '0 : div + 1'b1;
      h_last   = (hcnt == H_LAST_C);
      v_last   = (vcnt == V_LAST_C);
      hcnt_nxt = h_last ? '0 : hcnt + 1'b1;
      vcnt_nxt = vcnt;
      if (h_last) begin
         vcnt_nxt = v_last ? '0 : vcnt + 1'b1;
      end
   end

   // pix_en and vga_clk are registered copies of the divider phase so they
   // line up exactly with div without glitching.
   always_ff @(posedge clk) begin
      if (!reset) begin
         div         <= '0;
         pix_en      <= 1'b0;
         vga_clk     <= 1'b0;
         hcnt        <= '0;
         vcnt        <= '0;
         frame_start <= 1'b0;
      end else begin
         div         <= div_nxt;
         pix_en      <= (div_nxt == DIV_LAST);
         vga_clk     <= (div_nxt < DIV_HALF);
         frame_start <= pix_en && h_last && v_last;
         if (pix_en) begin
            hcnt <= hcnt_nxt;
            vcnt <= vcnt_nxt;
         end
      end
   end

   always_comb begin
      vblank = (vcnt >= V_ACT_C);
   end

   // Stage 0: decode the current raster position
   always_comb begin
      act0  = (hcnt < H_ACT_C) && (vcnt < V_ACT_C);
      hs0   = (hcnt >= HS_START_C) && (hcnt < HS_END_C);
      vs0   = (vcnt >= VS_START_C) && (vcnt < VS_END_C);
      row0  = ADDR_W'(vcnt >> SH);
      col0  = ADDR_W'(hcnt >> SH);
      addr0 = FB_BASE + (row0 * ROW_PIX_C + col0) * STRIDE_C;
   end

`ifdef VGA_TESTPAT_EN
   logic [HW-1:0] hcnt_d;
   logic [2:0]    bar;
   logic [23:0]   bar_rgb;

   always_comb begin
      bar     = 3'((32'(hcnt_d) << 3) / 32'(H_ACTIVE));
      bar_rgb = 24'h000000;
      case (bar)
         3'd0:    bar_rgb = 24'hFFFFFF;
         3'd1:    bar_rgb = 24'hFFFF00;
         3'd2:    bar_rgb = 24'h00FFFF;
         3'd3:    bar_rgb = 24'h00FF00;
         3'd4:    bar_rgb = 24'hFF00FF;
         3'd5:    bar_rgb = 24'hFF0000;
         3'd6:    bar_rgb = 24'h0000FF;
         default: bar_rgb = 24'h000000;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         hcnt_d <= '0;
      end else if (pix_en) begin
         hcnt_d <= hcnt;
      end
   end
`endif

   // Blanked pixels are forced to black whatever the memory returns.
   always_comb begin
      rgb_nxt = 24'h000000;
      if (act_d) begin
         rgb_nxt = fb.px_data;
`ifdef VGA_TESTPAT_EN
         if (test_en) begin
            rgb_nxt = bar_rgb;
         end
`endif
      end
   end

   // Stage 1 (address, delayed decode) and stage 2 (pins) both advance on pix_en.
   always_ff @(posedge clk) begin
      if (!reset) begin
         fb.fb_addr  <= FB_BASE;
         act_d       <= 1'b0;
         hs_d        <= 1'b0;
         vs_d        <= 1'b0;
         vga_hsync   <= ~HS_POL;
         vga_vsync   <= ~VS_POL;
         vga_blank_n <= 1'b0;
         vga_red     <= 8'h00;
         vga_green   <= 8'h00;
         vga_blue    <= 8'h00;
      end else if (pix_en) begin
         if (act0) begin
            fb.fb_addr <= addr0;
         end
         act_d       <= act0;
         hs_d        <= hs0;
         vs_d        <= vs0;
         vga_hsync   <= hs_d ^ ~HS_POL;
         vga_vsync   <= vs_d ^ ~VS_POL;
         vga_blank_n <= act_d;
         vga_red     <= rgb_nxt[23:16];
         vga_green   <= rgb_nxt[15:8];
         vga_blue    <= rgb_nxt[7:0];
      end
   end

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: two small-timing instances (SCALE 1 and SCALE 2) checked every clock
// against a raster model derived from clock count since reset.
module tb_vga_scanout;

   localparam int A_HA = 16, A_HFP = 2, A_HS = 3, A_HBP = 3;
   localparam int A_VA = 8,  A_VFP = 1, A_VS = 2, A_VBP = 1;
   localparam int A_DIV = 3, A_SCALE = 1, A_STRIDE = 4;
   localparam logic [31:0] A_BASE = 32'h0000_0100;
   localparam bit A_HPOL = 1'b0, A_VPOL = 1'b1;

   localparam int B_HA = 16, B_HFP = 2, B_HS = 2, B_HBP = 2;
   localparam int B_VA = 8,  B_VFP = 1, B_VS = 1, B_VBP = 2;
   localparam int B_DIV = 2, B_SCALE = 2, B_STRIDE = 4;
   localparam logic [31:0] B_BASE = 32'h0000_1000;
   localparam bit B_HPOL = 1'b1, B_VPOL = 1'b0;

   typedef struct packed {
      int ha; int hfp; int hs; int hbp;
      int va; int vfp; int vs; int vbp;
      int div; int scale; int stride;
      logic [31:0] base;
      bit hpol; bit vpol;
   } cfg_t;

   localparam cfg_t CFG_A = '{ha: A_HA, hfp: A_HFP, hs: A_HS, hbp: A_HBP,
                              va: A_VA, vfp: A_VFP, vs: A_VS, vbp: A_VBP,
                              div: A_DIV, scale: A_SCALE, stride: A_STRIDE,
                              base: A_BASE, hpol: A_HPOL, vpol: A_VPOL};
   localparam cfg_t CFG_B = '{ha: B_HA, hfp: B_HFP, hs: B_HS, hbp: B_HBP,
                              va: B_VA, vfp: B_VFP, vs: B_VS, vbp: B_VBP,
                              div: B_DIV, scale: B_SCALE, stride: B_STRIDE,
                              base: B_BASE, hpol: B_HPOL, vpol: B_VPOL};

   typedef struct packed {
      logic [31:0] fb_addr;
      logic        pix_en;
      logic        vga_clk;
      logic        hsync;
      logic        vsync;
      logic        blank_n;
      logic        frame_start;
      logic        vblank;
      logic [23:0] rgb;
   } obs_t;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   int n = 0;
   always @(posedge clk) n <= reset ? n + 1 : 0;

   // ---------------- DUTs and memory ----------------
   vga_scanout_if #(.ADDR_W(32)) mif_a ();
   vga_scanout_if #(.ADDR_W(32)) mif_b ();

   logic a_pix_en, a_vga_clk, a_hsync, a_vsync, a_blank_n, a_frame_start, a_vblank;
   logic b_pix_en, b_vga_clk, b_hsync, b_vsync, b_blank_n, b_frame_start, b_vblank;
   logic [7:0] a_r, a_g, a_b, b_r, b_g, b_b;

`ifdef VGA_TESTPAT_EN
   logic test_en = 1'b0;
   logic te_s = 1'b0;
   always @(posedge clk) te_s <= test_en;
`endif

   vga_scanout #(
      .H_ACTIVE(A_HA), .H_FP(A_HFP), .H_SYNC(A_HS), .H_BP(A_HBP),
      .V_ACTIVE(A_VA), .V_FP(A_VFP), .V_SYNC(A_VS), .V_BP(A_VBP),
      .HS_POL(A_HPOL), .VS_POL(A_VPOL), .CLK_DIV(A_DIV), .SCALE(A_SCALE),
      .ADDR_W(32), .FB_BASE(A_BASE), .STRIDE(A_STRIDE)
   ) dut_a (
      .clk(clk), .reset(reset),
`ifdef VGA_TESTPAT_EN
      .test_en(test_en),
`endif
      .fb(mif_a.master), .pix_en(a_pix_en), .vga_clk(a_vga_clk),
      .vga_hsync(a_hsync), .vga_vsync(a_vsync), .vga_blank_n(a_blank_n),
      .vga_red(a_r), .vga_green(a_g), .vga_blue(a_b),
      .frame_start(a_frame_start), .vblank(a_vblank)
   );

   vga_scanout #(
      .H_ACTIVE(B_HA), .H_FP(B_HFP), .H_SYNC(B_HS), .H_BP(B_HBP),
      .V_ACTIVE(B_VA), .V_FP(B_VFP), .V_SYNC(B_VS), .V_BP(B_VBP),
      .HS_POL(B_HPOL), .VS_POL(B_VPOL), .CLK_DIV(B_DIV), .SCALE(B_SCALE),
      .ADDR_W(32), .FB_BASE(B_BASE), .STRIDE(B_STRIDE)
   ) dut_b (
      .clk(clk), .reset(reset),
`ifdef VGA_TESTPAT_EN
      .test_en(test_en),
`endif
      .fb(mif_b.master), .pix_en(b_pix_en), .vga_clk(b_vga_clk),
      .vga_hsync(b_hsync), .vga_vsync(b_vsync), .vga_blank_n(b_blank_n),
      .vga_red(b_r), .vga_green(b_g), .vga_blue(b_b),
      .frame_start(b_frame_start), .vblank(b_vblank)
   );

   logic [31:0] mem_seed = 32'h0;
   bit          mem_white = 1'b0;

   function automatic logic [23:0] mem_pat(input logic [31:0] a);
      logic [31:0] t;
      t = (a * 32'h9E37_79B1) ^ mem_seed;
      return mem_white ? 24'hFFFFFF : t[31:8];
   endfunction

   // One-clock read latency memory
   always @(posedge clk) begin
      mif_a.px_data <= mem_pat(mif_a.fb_addr);
      mif_b.px_data <= mem_pat(mif_b.fb_addr);
   end

   // ---------------- reference model ----------------
   function automatic void pix_pos(input cfg_t c, input int k, output int h, output int v);
      int ht, vt;
      ht = c.ha + c.hfp + c.hs + c.hbp;
      vt = c.va + c.vfp + c.vs + c.vbp;
      h  = k % ht;
      v  = (k / ht) % vt;
   endfunction

   function automatic bit px_act(input cfg_t c, input int k);
      int h, v;
      pix_pos(c, k, h, v);
      return (h < c.ha) && (v < c.va);
   endfunction

   function automatic logic [31:0] px_addr(input cfg_t c, input int k);
      int h, v;
      pix_pos(c, k, h, v);
      return c.base + 32'(((v / c.scale) * (c.ha / c.scale) + h / c.scale) * c.stride);
   endfunction

   function automatic logic [23:0] bar_color(input int idx);
      case (idx)
         0: return 24'hFFFFFF;
         1: return 24'hFFFF00;
         2: return 24'h00FFFF;
         3: return 24'h00FF00;
         4: return 24'hFF00FF;
         5: return 24'hFF0000;
         6: return 24'h0000FF;
         default: return 24'h000000;
      endcase
   endfunction

   // {bar colour, blank_n, hsync, vsync, rgb} seen at the pins two periods later
   function automatic logic [50:0] exp_word(input cfg_t c, input int k);
      int h, v;
      bit act, hs_on, vs_on;
      logic [23:0] rgb, bar;
      pix_pos(c, k, h, v);
      act   = (h < c.ha) && (v < c.va);
      hs_on = (h >= c.ha + c.hfp) && (h < c.ha + c.hfp + c.hs);
      vs_on = (v >= c.va + c.vfp) && (v < c.va + c.vfp + c.vs);
      rgb   = act ? mem_pat(px_addr(c, k)) : 24'h0;
      bar   = act ? bar_color(h * 8 / c.ha) : 24'h0;
      return {bar, act, (hs_on ? c.hpol : ~c.hpol), (vs_on ? c.vpol : ~c.vpol), rgb};
   endfunction

   // ---------------- scoreboard ----------------
   logic [50:0] exp_q_a[$];
   logic [50:0] exp_q_b[$];
   logic [31:0] held[2];
   logic [26:0] cur[2];
   int n_checks = 0;
   int n_errors = 0;
   bit scoring = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s n=%0d got=%0h exp=%0h", tag, n, got, exp);
      end
   endtask

   task automatic score(input int id, input cfg_t c, input obs_t o);
      int d, p, h, v, frame;
      logic [50:0] w;
      string t;
      t     = (id == 0) ? "a" : "b";
      d     = n % c.div;
      p     = n / c.div;
      frame = (c.ha + c.hfp + c.hs + c.hbp) * (c.va + c.vfp + c.vs + c.vbp);
      if (n == 0) begin
         if (id == 0) exp_q_a.delete(); else exp_q_b.delete();
         held[id] = c.base;
      end
      if (d == 0) begin
         if (p > 0 && px_act(c, p - 1)) held[id] = px_addr(c, p - 1);
         w = {24'h0, 1'b0, ~c.hpol, ~c.vpol, 24'h0};
         if (id == 0) begin
            exp_q_a.push_back(exp_word(c, p));
            if (exp_q_a.size() > 2) w = exp_q_a.pop_front();
         end else begin
            exp_q_b.push_back(exp_word(c, p));
            if (exp_q_b.size() > 2) w = exp_q_b.pop_front();
         end
`ifdef VGA_TESTPAT_EN
         if (te_s) w[23:0] = w[50:27];
`endif
         cur[id] = w[26:0];
      end
      pix_pos(c, p, h, v);
      check({t, ".fb_addr"},     o.fb_addr,            held[id]);
      check({t, ".pix_en"},      32'(o.pix_en),        32'(d == c.div - 1));
      check({t, ".vga_clk"},     32'(o.vga_clk),       32'(n != 0 && d < c.div / 2));
      check({t, ".frame_start"}, 32'(o.frame_start),   32'(n > 0 && d == 0 && (p % frame) == 0));
      check({t, ".vblank"},      32'(o.vblank),        32'(v >= c.va));
      check({t, ".blank_n"},     32'(o.blank_n),       32'(cur[id][26]));
      check({t, ".hsync"},       32'(o.hsync),         32'(cur[id][25]));
      check({t, ".vsync"},       32'(o.vsync),         32'(cur[id][24]));
      check({t, ".rgb"},         32'(o.rgb),           32'(cur[id][23:0]));
   endtask

   obs_t oa, ob;
   always_comb begin
      oa = {mif_a.fb_addr, a_pix_en, a_vga_clk, a_hsync, a_vsync, a_blank_n,
            a_frame_start, a_vblank, a_r, a_g, a_b};
      ob = {mif_b.fb_addr, b_pix_en, b_vga_clk, b_hsync, b_vsync, b_blank_n,
            b_frame_start, b_vblank, b_r, b_g, b_b};
   end

   always @(negedge clk) begin
      if (scoring) begin
         score(0, CFG_A, oa);
         score(1, CFG_B, ob);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic do_reset(input int cycles, input bit white);
      @(negedge clk);
      reset     = 1'b0;
      mem_white = white;
      mem_seed  = $urandom;
      repeat (cycles) @(negedge clk);
      scoring = 1'b1;
      reset   = 1'b1;
   endtask

   task automatic run(input int cycles);
      repeat (cycles) begin
         @(negedge clk);
`ifdef VGA_TESTPAT_EN
         if ($urandom_range(0, 63) == 0) test_en = ~test_en;
`endif
      end
   endtask

   // ---------------- stimulus and report ----------------
   initial begin
      do_reset(2, 1'b0);
      run(1900 + $urandom_range(0, 300));
      do_reset($urandom_range(1, 3), 1'b1);
      run(1100);
      do_reset(1, 1'b0);
      run(1500 + $urandom_range(0, 200));
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
